matrix_result_tx: RTL and testbench
===================================

# matrix_result_tx

Streams a computed result matrix out of its result memory over the UART transmitter, byte by byte, using the transmitter's start/busy handshake. Sits between the result `matrix_memory` (read port) and `uart_tx`, alongside `control_unit`, which pulses `start` once the product is ready. It is the outbound counterpart of the receive path that loads matrices A and B from `rx_data`.

## Interface
- `MAX_N`, 4: largest supported matrix dimension; memory depth is `MAX_N*MAX_N`
- `DATA_W`, 32: result word width; must be a multiple of 8
- `ADDR_W`, 4: memory address width; `2**ADDR_W >= MAX_N*MAX_N`

- `clk` in 1: system clock; the single clock for the whole block
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; begin transmitting a frame
- `matrix_size` in 4: N, sampled on `start`
- `rd_addr` out ADDR_W: result memory read address
- `rd_data` in DATA_W: result memory read data, valid one cycle after `rd_addr`
- `tx_data` out 8: byte to the transmitter
- `tx_start` out 1: byte request to the transmitter
- `tx_busy` in 1: transmitter busy, already synchronised to `clk`
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse at end of frame
- `err` out 1: valid with `done`; frame was rejected

## Operation
- Frame format:
  - Header byte `{4'h0, N}`.
  - Then N*N words, addresses 0 to N*N-1, row-major.
  - Each word is sent as `DATA_W/8` bytes, most significant byte first.
  - Total bytes = 1 + (DATA_W/8)*N*N; 65 bytes for N=4, DATA_W=32.
- States:
  - IDLE: on `start`, go to CHECK.
  - CHECK: if N=0 or N>MAX_N, go to DONE with `err`=1, sending no bytes; otherwise load the header into the byte register and go to SEND.
  - FETCH: drive `rd_addr` and go to LATCH.
  - LATCH: capture `rd_data` into the word shift register, load its top byte and go to SEND.
  - SEND: wait until `tx_busy`=0, then raise `tx_start`; hold it with `tx_data` stable until `tx_busy`=1 is seen, then drop it and go to DRAIN.
  - DRAIN: wait for `tx_busy`=0, then go to NEXT.
  - NEXT:
    - If bytes remain in the current word, shift it left 8 bits and go to SEND.
    - Else if words remain, increment the address and go to FETCH.
    - Else go to DONE.
  - DONE: pulse `done` (with `err`) for one cycle and return to IDLE.
- Counters:
  - Byte index is 0..DATA_W/8-1 and wraps to 0 when each word is finished.
  - Word count is compared against N*N, computed once in CHECK as a 5-bit product (max 16, no overflow).
- `start` while `busy`=1 is ignored; the frame in progress is unaffected.
- `matrix_size` is sampled on `start` only; later changes have no effect on the current frame.
- `busy`=1 from the cycle after `start` until the cycle `done` pulses, inclusive.

## Timing
- Reset values: `rd_addr`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `done`=0, `err`=0; state is IDLE.
- Reset mid-frame: all outputs take their reset values immediately (asynchronously), including `tx_start`. No resume: the next `start` begins a new frame with the header.
- `start` to first `tx_start`: 2 cycles when `tx_busy`=0 (IDLE→CHECK→SEND).
- Memory read: `rd_addr` is presented in FETCH and `rd_data` is sampled in LATCH, exactly 1 cycle later.
- Handshake with `tx_busy`:
  - `tx_start` stays high for any number of cycles until `tx_busy` rises, which tolerates a slower baud clock.
  - `tx_start` is never high while a previous byte's `tx_busy` is still asserted.
  - If `tx_busy` is already 1 on entry to SEND, `tx_start` stays low until it clears.
- Rejected frame: `done` and `err` assert 2 cycles after `start`.

## Structure
- Shared package `matrix_pkg`:
  - state encoding for IDLE/CHECK/FETCH/LATCH/SEND/DRAIN/NEXT/DONE
  - `HDR_PREFIX` = 4'h0
  - `BYTES_PER_WORD` = DATA_W/8
  - `MAX_N`
- One natural sub-module, `tx_byte_handshake`: owns SEND/DRAIN, with inputs `req`/`byte`/`tx_busy`, outputs `tx_start`/`tx_data`/`ack`. The top FSM handles fetch and sequencing.

## Test plan
- N=2, memory {0x11223344, 0xAABBCCDD, 0, 0xFFFFFFFF}, transmitter model with a 10-cycle busy → bytes 02 11 22 33 44 AA BB CC DD 00 00 00 00 FF FF FF FF, then a `done` pulse with `err`=0.
- N=4, incrementing words → 65 bytes; `rd_addr` steps 0..15 exactly once each; `busy` high for the whole frame.
- N=0 and N=5 → `done`=1 and `err`=1 two cycles after `start`; `tx_start` never asserts.
- `tx_busy` held high for 50 cycles at `start`, and the transmitter delaying its busy response by 7 cycles → `tx_start` stays low until busy clears, then stays high until busy rises; no byte is lost or duplicated.
- Second `start` mid-frame, then `rst` asserted after byte 5 → the second `start` is ignored; on reset all outputs are 0 immediately; the next `start` restarts with the header byte.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared state encoding and constants for the result transmit path.
package matrix_pkg;
  localparam int MAX_N = 4;
  localparam int DATA_W = 32;
  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam logic [3:0] HDR_PREFIX = 4'h0;
  typedef enum logic [2:0] {IDLE, CHECK, FETCH, LATCH, SEND, DRAIN, NEXT, DONE} state_t;
endpackage

// File: rtl/tx_byte_handshake.sv
// tx_byte_handshake: start/busy handshake for one byte; ack when the transmitter has drained it.
module tx_byte_handshake
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       ack
);
  state_t ph_q, ph_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ph_q <= IDLE;
    else ph_q <= ph_d;
  end
  // tx_start is gated by tx_busy so it can never overlap a busy transmitter
  always_comb begin
    tx_start = req && !tx_busy && ph_q != DRAIN;
    ack = req && ph_q == DRAIN && !tx_busy;
    ph_d = !req ? IDLE :
           (ph_q == IDLE && !tx_busy) ? SEND :
           (ph_q == SEND && tx_busy) ? DRAIN :
           ack ? IDLE : ph_q;
  end
  assign tx_data = tx_byte;
endmodule

// File: rtl/matrix_result_tx.sv
// matrix_result_tx: streams header {0,N} then N*N result words MSB-first over the UART handshake.
module matrix_result_tx #(
  parameter int MAX_N  = matrix_pkg::MAX_N,
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import matrix_pkg::*;
  localparam int BPW = DATA_W / 8;
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  localparam logic [3:0] MAX_N4 = 4'(MAX_N);
  state_t state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [4:0] total_q, total_d, wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [DATA_W-1:0] word_q, word_d, word_sh;
  logic [7:0] byte_q, byte_d;
  logic hdr_q, hdr_d, err_q, err_d, ack;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q <= '0;
      total_q <= '0;
      wcnt_q <= '0;
      addr_q <= '0;
      bidx_q <= '0;
      word_q <= '0;
      byte_q <= '0;
      hdr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      total_q <= total_d;
      wcnt_q <= wcnt_d;
      addr_q <= addr_d;
      bidx_q <= bidx_d;
      word_q <= word_d;
      byte_q <= byte_d;
      hdr_q <= hdr_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    word_sh = word_q << 8;
    state_d = state_q;
    n_d = n_q;
    total_d = total_q;
    wcnt_d = wcnt_q;
    addr_d = addr_q;
    bidx_d = bidx_q;
    word_d = word_q;
    byte_d = byte_q;
    hdr_d = hdr_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        n_d = matrix_size;
        state_d = CHECK;
      end
      CHECK: if (n_q == 4'd0 || n_q > MAX_N4) begin
        err_d = 1'b1;
        state_d = DONE;
      end else begin
        err_d = 1'b0;
        total_d = 5'(n_q) * 5'(n_q);
        wcnt_d = '0;
        addr_d = '0;
        bidx_d = '0;
        hdr_d = 1'b1;
        byte_d = {HDR_PREFIX, n_q};
        state_d = SEND;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d = rd_data;
        byte_d = rd_data[DATA_W-1 -: 8];
        state_d = SEND;
      end
      SEND: if (ack) state_d = NEXT;
      // the header is a lone byte, so it goes straight to the first fetch
      NEXT: if (hdr_q) begin
        hdr_d = 1'b0;
        state_d = FETCH;
      end else if (bidx_q != BW'(BPW - 1)) begin
        bidx_d = bidx_q + BW'(1);
        word_d = word_sh;
        byte_d = word_sh[DATA_W-1 -: 8];
        state_d = SEND;
      end else if (wcnt_q + 5'd1 < total_q) begin
        bidx_d = '0;
        wcnt_d = wcnt_q + 5'd1;
        addr_d = addr_q + ADDR_W'(1);
        state_d = FETCH;
      end else begin
        bidx_d = '0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign rd_addr = addr_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = done && err_q;
  tx_byte_handshake u_hs (
    .clk(clk),
    .rst(rst),
    .req(state_q == SEND),
    .tx_byte(byte_q),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .ack(ack)
  );
endmodule

// File: tb/tb_matrix_result_tx.sv
// tb_matrix_result_tx: randomized frames against a byte-list model of the result transmit path.
module tb_matrix_result_tx;
  logic clk = 1'b0, rst, start, tx_busy, tx_start, busy, done, err;
  logic [3:0] matrix_size, rd_addr;
  logic [31:0] rd_data;
  logic [7:0] tx_data;
  logic [31:0] mem [16];
  logic [7:0] got_arr [4096];
  logic [7:0] exp_arr [128];
  logic [7:0] lit [17] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int nbytes = 0, exp_base = 0, exp_len = 0, chk_idx = 0;
  int checks = 0, fails = 0, resp_dly = 0, busy_len = 10, cnt = 0, b0;
  logic mbusy, pend, ext_busy;
  logic [7:0] hold;

  always #5 clk = ~clk;

  matrix_result_tx dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) rd_data <= mem[rd_addr];
  assign tx_busy = mbusy | ext_busy;

  // transmitter: captures on start while idle, raises busy after resp_dly, holds busy_len cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mbusy <= 1'b0;
      pend <= 1'b0;
      cnt <= 0;
    end else if (pend) begin
      if (cnt == 0) begin
        pend <= 1'b0;
        mbusy <= 1'b1;
        cnt <= busy_len - 1;
      end else cnt <= cnt - 1;
    end else if (mbusy) begin
      if (cnt == 0) mbusy <= 1'b0;
      else cnt <= cnt - 1;
    end else if (tx_start && !tx_busy) begin
      pend <= 1'b1;
      cnt <= resp_dly;
      hold <= tx_data;
      got_arr[nbytes] <= tx_data;
      nbytes <= nbytes + 1;
    end
  end

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void build(input int n);
    exp_base = nbytes;
    exp_len = 0;
    if (n >= 1 && n <= 4) begin
      exp_arr[0] = 8'(n);
      for (int w = 0; w < n * n; w++)
        for (int b = 0; b < 4; b++) exp_arr[1 + 4 * w + b] = 8'(mem[w] >> (24 - 8 * b));
      exp_len = 1 + 4 * n * n;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    while (chk_idx < nbytes) begin
      chk(chk_idx - exp_base < exp_len && got_arr[chk_idx] == exp_arr[chk_idx - exp_base], "tx_byte",
          got_arr[chk_idx], (chk_idx - exp_base < exp_len) ? exp_arr[chk_idx - exp_base] : 32'hDEAD);
      chk_idx++;
    end
    if (tx_start) chk(!tx_busy, "start_while_busy", tx_busy, 0);
    if (tx_start && pend) chk(tx_data == hold, "tx_data_stable", tx_data, hold);
  endtask

  task automatic run_frame(input int n, input int budget);
    int nn, last;
    bit rej, got_done, seq_ok;
    nn = (n >= 1 && n <= 4) ? n * n : 0;
    rej = nn == 0;
    build(n);
    start = 1'b1;
    matrix_size = 4'(n);
    tick();
    start = 1'b0;
    matrix_size = 4'($urandom);
    chk(busy && !done, "busy_after_start", {busy, done}, 2'b10);
    got_done = 0;
    last = -1;
    seq_ok = 1;
    for (int k = 0; k < budget && !got_done; k++) begin
      tick();
      if (k == 0 && rej) chk(done && err, "reject_2cyc", {done, err}, 2'b11);
      if (k == 0 && !rej && !tx_busy) chk(tx_start && tx_data == exp_arr[0], "first_start_2cyc", {tx_start, tx_data}, {1'b1, exp_arr[0]});
      if (!rej && busy && int'(rd_addr) != last) begin
        if (int'(rd_addr) != last + 1) seq_ok = 0;
        last = int'(rd_addr);
      end
      if (done) begin
        got_done = 1;
        chk(err == rej, "err", err, rej);
        chk(busy, "busy_at_done", busy, 1);
        chk(nbytes - exp_base == exp_len, "byte_count", nbytes - exp_base, exp_len);
      end else chk(busy, "busy_in_frame", busy, 1);
    end
    chk(got_done, "done_timeout", got_done, 1);
    if (!rej) chk(seq_ok && last == nn - 1, "rd_addr_seq", last, nn - 1);
    tick();
    chk(!done && !busy, "done_one_cycle", {done, busy}, 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    matrix_size = 4'd0;
    ext_busy = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk({rd_addr, tx_data, tx_start, busy, done, err} == 0, "reset_values", {rd_addr, tx_data, tx_start, busy, done, err}, 0);
    rst = 1'b1;
    tick();
    mem[0] = 32'h11223344; mem[1] = 32'hAABBCCDD; mem[2] = 32'h0; mem[3] = 32'hFFFFFFFF;
    b0 = nbytes;
    run_frame(2, 2000);
    for (int i = 0; i < 17; i++) chk(got_arr[b0 + i] == lit[i], "n2_literal", got_arr[b0 + i], lit[i]);
    for (int i = 0; i < 16; i++) mem[i] = 32'h10203040 + i;
    busy_len = 3;
    resp_dly = 1;
    run_frame(4, 3000);
    run_frame(0, 10);
    run_frame(5, 10);
    ext_busy = 1'b1;
    resp_dly = 7;
    busy_len = 4;
    fork
      begin
        repeat (50) @(negedge clk);
        ext_busy = 1'b0;
      end
    join_none
    run_frame(3, 3000);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      busy_len = $urandom_range(1, 12);
      resp_dly = $urandom_range(0, 5);
      run_frame($urandom_range(0, 5), 5000);
    end
    busy_len = 6;
    resp_dly = 2;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    build(3);
    start = 1'b1;
    matrix_size = 4'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3000 && nbytes - exp_base < 2; k++) tick();
    start = 1'b1;
    matrix_size = 4'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3000 && nbytes - exp_base < 5; k++) tick();
    chk(nbytes - exp_base >= 5, "reach_byte5", nbytes - exp_base, 5);
    chk(busy, "busy_before_reset", busy, 1);
    #2 rst = 1'b0;
    #1 chk({rd_addr, tx_data, tx_start, busy, done, err} == 0, "async_reset_outputs", {rd_addr, tx_data, tx_start, busy, done, err}, 0);
    tick();
    rst = 1'b1;
    tick();
    run_frame(2, 3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
